// File: rtl/gfx_pkg.sv
// Shared types and constants for the GBA bitmap-mode line renderer.
package gfx_pkg;

  localparam logic [2:0] MODE3 = 3'd3;
  localparam logic [2:0] MODE4 = 3'd4;
  localparam logic [2:0] MODE5 = 3'd5;

  localparam int DC_MODE_LSB = 0;
  localparam int DC_MODE_MSB = 2;
  localparam int DC_FRAME    = 4;
  localparam int DC_BLANK    = 7;

  typedef logic [14:0] bgr555_t;

  localparam bgr555_t BLACK = 15'h0000;
  localparam bgr555_t WHITE = 15'h7FFF;

  localparam int M5_W = 160;
  localparam int M5_H = 128;

  typedef enum logic [1:0] {
    PIX_BLACK,
    PIX_WHITE,
    PIX_DIRECT,
    PIX_PAL
  } pix_kind_e;

  typedef struct packed {
    logic      vld;
    pix_kind_e kind;
    logic [9:0] col;
  } pix_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/gfx_line_buffer.sv
// Ping-pong scanline buffer: one write port into the back bank, one registered
// read port from the display bank. swap_i flips the banks.
module gfx_line_buffer
  import gfx_pkg::*;
#(
  parameter int H_RES   = 240,
  parameter int COLOR_W = 15
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               swap_i,
  input  logic               we_i,
  input  logic [9:0]         waddr_i,
  input  logic [COLOR_W-1:0] wdata_i,
  input  logic [9:0]         raddr_i,
  output logic [COLOR_W-1:0] rdata_o
);

  localparam int         IDX_W = $clog2(2 * H_RES);
  localparam logic [9:0] H_END = 10'(H_RES);

  logic [COLOR_W-1:0] mem_q [2*H_RES];
  logic               bank_q;
  logic               bank_d;
  logic [COLOR_W-1:0] rdata_q;

  function automatic logic [IDX_W-1:0] idx(input logic bank, input logic [9:0] col);
    return bank ? IDX_W'(H_RES) + IDX_W'(col) : IDX_W'(col);
  endfunction

  // A read in the swap cycle already sees the new display bank.
  assign bank_d = swap_i ? ~bank_q : bank_q;

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i < H_END)) begin
      mem_q[idx(~bank_q, waddr_i)] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      bank_q  <= bank_d;
      rdata_q <= (raddr_i < H_END) ? mem_q[idx(bank_d, raddr_i)] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gfx_bitmap_line_renderer.sv
// Renders GBA bitmap modes 3/4/5 one scanline ahead into a ping-pong buffer.
// Optional feature macro: GFX_FORCED_BLANK_EN (dispcnt[7] forces white lines).
module gfx_bitmap_line_renderer
  import gfx_pkg::*;
#(
  parameter int          H_RES      = 240,
  parameter int          V_RES      = 160,
  parameter int          ADDR_W     = 16,
  parameter int          COLOR_W    = 15,
  parameter int          VRAM_LAT   = 1,
  parameter int          PAL_LAT    = 1,
  parameter logic [15:0] PAGE1_BASE = 16'h5000
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [15:0]        dispcnt,
  input  logic               line_start,
  input  logic [8:0]         line_num,
  output logic [ADDR_W-1:0]  vram_addr,
  output logic               vram_rd,
  input  logic [15:0]        vram_data,
  output logic [7:0]         palette_addr,
  input  logic [15:0]        palette_data,
  input  logic [9:0]         pix_col,
  output logic [COLOR_W-1:0] pix_data,
  output logic               busy,
  output logic               overrun
);

  localparam int               N_TAG      = VRAM_LAT + PAL_LAT + 1;
  localparam int               DRAIN_N    = VRAM_LAT + PAL_LAT;
  localparam int               CNT_W      = $clog2(DRAIN_N + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_N - 1);
  localparam logic [9:0]       H_LAST     = 10'(H_RES - 1);
  localparam logic [8:0]       V_END      = 9'(V_RES);
  localparam logic [9:0]       M5_W10     = 10'(M5_W);
  localparam logic [8:0]       M5_H9      = 9'(M5_H);

  state_e              state_q, state_d;
  logic [9:0]          col_q, col_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          mode_q;
  logic                fs_q;
  logic [8:0]          row_q;
  logic                overrun_q;
  logic                blank_line;
  pix_kind_e           issue_kind;
  logic                fill;
  pix_tag_t            tag_q [N_TAG];
  pix_tag_t            ptag;
  pix_tag_t            wtag;
  logic [7:0]          pal_idx_q;
  logic [COLOR_W-1:0]  dly_q [PAL_LAT+1];
  logic [COLOR_W-1:0]  wdata;
  logic                unused_bits;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [2:0] mode, input logic fs,
                                                 input logic [8:0] r, input logic [9:0] c);
    logic [ADDR_W-1:0] base, ra, ca;
    base = fs ? ADDR_W'(PAGE1_BASE) : '0;
    ra   = ADDR_W'(r);
    ca   = ADDR_W'(c);
    case (mode)
      MODE4:   return ra * ADDR_W'(120) + (ca >> 1) + base;
      MODE5:   return ra * ADDR_W'(M5_W) + ca + base;
      default: return ra * ADDR_W'(240) + ca;
    endcase
  endfunction

`ifdef GFX_FORCED_BLANK_EN
  logic blank_q;
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      blank_q <= 1'b0;
    end else if (line_start) begin
      blank_q <= dispcnt[DC_BLANK];
    end
  end
  assign blank_line = blank_q;
`else
  assign blank_line = 1'b0;
`endif

  // Control state; line config is sampled only at line_start.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= '0;
      fs_q      <= 1'b0;
      row_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      if (line_start) begin
        mode_q <= dispcnt[DC_MODE_MSB:DC_MODE_LSB];
        fs_q   <= dispcnt[DC_FRAME];
        row_q  <= line_num;
        if (busy) overrun_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_FILL: begin
        if (col_q == H_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          col_d = col_q + 10'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = ST_IDLE;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
    if (line_start) begin
      state_d = ST_FILL;
      col_d   = '0;
      cnt_d   = '0;
    end
  end

  always_comb begin
    issue_kind = PIX_BLACK;
    if (blank_line) begin
      issue_kind = PIX_WHITE;
    end else if (row_q < V_END) begin
      case (mode_q)
        MODE3:   issue_kind = PIX_DIRECT;
        MODE4:   issue_kind = PIX_PAL;
        MODE5:   if ((col_q < M5_W10) && (row_q < M5_H9)) issue_kind = PIX_DIRECT;
        default: issue_kind = PIX_BLACK;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;
  assign fill      = (state_q == ST_FILL);
  assign vram_rd   = fill && ((issue_kind == PIX_DIRECT) || (issue_kind == PIX_PAL));
  assign vram_addr = vram_rd ? pix_addr(mode_q, fs_q, row_q, col_q) : '0;

  // Tag pipeline: issue cycle -> VRAM return -> palette stage -> buffer write.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < N_TAG; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{vld: fill, kind: issue_kind, col: col_q};
      for (int i = 1; i < N_TAG; i++) tag_q[i] <= tag_q[i-1];
      if (line_start && busy) begin
        for (int i = 0; i < N_TAG; i++) tag_q[i].vld <= 1'b0;
      end
    end
  end

  assign ptag = tag_q[VRAM_LAT-1];
  assign wtag = tag_q[N_TAG-1];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pal_idx_q <= '0;
    end else if (ptag.vld && (ptag.kind == PIX_PAL)) begin
      pal_idx_q <= ptag.col[0] ? vram_data[15:8] : vram_data[7:0];
    end
  end

  assign palette_addr = pal_idx_q;

  // Direct-colour data waits out the palette stage so both paths align.
  always_ff @(posedge clk) begin
    dly_q[0] <= vram_data[COLOR_W-1:0];
    for (int i = 1; i <= PAL_LAT; i++) dly_q[i] <= dly_q[i-1];
  end

  always_comb begin
    wdata = '0;
    case (wtag.kind)
      PIX_WHITE:  wdata = COLOR_W'(WHITE);
      PIX_DIRECT: wdata = dly_q[PAL_LAT];
      PIX_PAL:    wdata = palette_data[COLOR_W-1:0];
      default:    wdata = COLOR_W'(BLACK);
    endcase
  end

  gfx_line_buffer #(
    .H_RES   (H_RES),
    .COLOR_W (COLOR_W)
  ) u_line_buffer (
    .clk_i   (clk),
    .rst_ni  (clrn),
    .swap_i  (line_start),
    .we_i    (wtag.vld),
    .waddr_i (wtag.col),
    .wdata_i (wdata),
    .raddr_i (pix_col),
    .rdata_o (pix_data)
  );

  assign unused_bits = ^{dispcnt[15:8], dispcnt[7], dispcnt[6:5], dispcnt[3], palette_data[15]};

endmodule

// File: tb/tb_gfx_bitmap_line_renderer.sv
// Scoreboard bench: renders random and directed lines, reads them back on the next line.
module tb_gfx_bitmap_line_renderer;

  localparam int H   = 240;
  localparam int V   = 160;
  localparam int VL  = 1;
  localparam int PL  = 1;
  localparam int LAT = H + VL + PL + 1;
  localparam int PER = H + 8;

  logic        clk = 1'b0;
  logic        clrn;
  logic [15:0] dispcnt = '0;
  logic        line_start = 1'b0;
  logic [8:0]  line_num = '0;
  logic [15:0] vram_addr;
  logic        vram_rd;
  logic [15:0] vram_data = '0;
  logic [7:0]  palette_addr;
  logic [15:0] palette_data = '0;
  logic [9:0]  pix_col = '0;
  logic [14:0] pix_data;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  gfx_bitmap_line_renderer #(
    .H_RES(H), .V_RES(V), .ADDR_W(16), .COLOR_W(15),
    .VRAM_LAT(VL), .PAL_LAT(PL), .PAGE1_BASE(16'h5000)
  ) dut (
    .clk(clk), .clrn(clrn), .dispcnt(dispcnt), .line_start(line_start),
    .line_num(line_num), .vram_addr(vram_addr), .vram_rd(vram_rd),
    .vram_data(vram_data), .palette_addr(palette_addr), .palette_data(palette_data),
    .pix_col(pix_col), .pix_data(pix_data), .busy(busy), .overrun(overrun)
  );

  logic [15:0] vram [65536];
  logic [15:0] pal  [256];
  int          rd_cnt = 0;

  always @(posedge clk) begin
    vram_data    <= vram_rd ? vram[vram_addr] : 16'hDEAD;
    palette_data <= pal[palette_addr];
    if (vram_rd) rd_cnt++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: {col, expected pixel} pushed when pix_col is driven.
  logic [24:0] exp_q[$];
  bit          rd_req = 1'b0;
  bit          rd_pend = 1'b0;

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    logic [24:0] e;
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        check("scoreboard underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("pix_data col %0d", e[24:15]), {17'd0, pix_data}, {17'd0, e[14:0]});
      end
    end
  end

  function automatic logic [14:0] ref_pix(input logic [15:0] dc, input int row, input int c);
    int          base;
    logic [15:0] w;
    logic [15:0] p;
    base = dc[4] ? 'h5000 : 0;
`ifdef GFX_FORCED_BLANK_EN
    if (dc[7]) return 15'h7FFF;
`endif
    if (row >= V) return 15'h0;
    case (int'(dc[2:0]))
      3: begin
        w = vram[(row * 240 + c) % 65536];
        return w[14:0];
      end
      4: begin
        w = vram[(row * 120 + c / 2 + base) % 65536];
        p = pal[(c % 2 == 1) ? w[15:8] : w[7:0]];
        return p[14:0];
      end
      5: begin
        if (c >= 160 || row >= 128) return 15'h0;
        w = vram[(row * 160 + c + base) % 65536];
        return w[14:0];
      end
      default: return 15'h0;
    endcase
  endfunction

  function automatic int ref_reads(input logic [15:0] dc, input int row);
    int n;
    n = 0;
    for (int c = 0; c < H; c++) begin
      if (row < V && (dc[2:0] == 3'd3 || dc[2:0] == 3'd4 ||
                      (dc[2:0] == 3'd5 && c < 160 && row < 128))) n++;
    end
`ifdef GFX_FORCED_BLANK_EN
    if (dc[7]) n = 0;
`endif
    return n;
  endfunction

  logic [14:0] prev_line [H];
  int          prev_reads = 0;
  bit          prev_known = 1'b0;
  int          rd_snap = 0;

  // Pulse line_start for a new line; meanwhile read back the line now on display.
  task automatic run_line(input logic [15:0] dc, input int row, input bit chk_pix, input int ncyc);
    logic [14:0] new_line [H];
    for (int c = 0; c < H; c++) new_line[c] = ref_pix(dc, row, c);
    if (prev_known) check("vram_rd count", rd_cnt - rd_snap, prev_reads);
    dispcnt    = dc;
    line_num   = row[8:0];
    line_start = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (chk_pix && i < PER) begin
        pix_col = i[9:0];
        exp_q.push_back({i[9:0], (i < H) ? prev_line[i] : 15'h0});
        rd_req = 1'b1;
      end else begin
        rd_req  = 1'b0;
        pix_col = 10'($urandom_range(0, 1023));
      end
      @(negedge clk);
      line_start = 1'b0;
      if (i == 0) rd_snap = rd_cnt;
      if (i == 5) check("busy while rendering", {31'd0, busy}, 32'd1);
      if (i == LAT) check("busy clear after latency", {31'd0, busy}, 32'd0);
    end
    rd_req     = 1'b0;
    prev_line  = new_line;
    prev_reads = ref_reads(dc, row);
    prev_known = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dc;
    int          row;
    int          modes [9] = '{3, 4, 5, 3, 4, 5, 0, 1, 7};

    for (int a = 0; a < 65536; a++) vram[a] = 16'($urandom);
    for (int a = 0; a < 256; a++) pal[a] = 16'($urandom);

    clrn = 1'b0;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset overrun", {31'd0, overrun}, 32'd0);
    check("reset vram_rd", {31'd0, vram_rd}, 32'd0);
    check("reset vram_addr", {16'd0, vram_addr}, 32'd0);
    check("reset palette_addr", {24'd0, palette_addr}, 32'd0);
    check("reset pix_data", {17'd0, pix_data}, 32'd0);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);

    // Mode 3, VRAM[i]=i on line 5.
    for (int c = 0; c < H; c++) vram[1200 + c] = 16'(1200 + c);
    run_line(16'h0003, 5, 1'b0, PER);
    // Mode 4, page 1, line 2 with the known byte pair.
    vram['h5000 + 240] = 16'hBBAA;
    pal['hAA] = 16'h001F;
    pal['hBB] = 16'h03E0;
    run_line(16'h0014, 2, 1'b1, PER);
    run_line(16'h0005, 10, 1'b1, PER);
    run_line(16'h0005, 130, 1'b1, PER);
    run_line(16'h0015, 127, 1'b1, PER);
    run_line(16'h0003, 200, 1'b1, PER);
    run_line(16'h0000, 20, 1'b1, PER);
    run_line(16'h0003, 159, 1'b1, PER);
`ifdef GFX_FORCED_BLANK_EN
    run_line(16'h0083, 7, 1'b1, PER);
`endif

    // Overrun: restart 50 cycles into a line.
    check("overrun before restart", {31'd0, overrun}, 32'd0);
    run_line(16'h0003, 40, 1'b1, 50);
    prev_known = 1'b0;
    run_line(16'h0004, 41, 1'b0, PER);
    check("overrun after restart", {31'd0, overrun}, 32'd1);
    run_line(16'h0005, 60, 1'b1, PER);
    check("overrun sticky", {31'd0, overrun}, 32'd1);

    for (int k = 0; k < 12; k++) begin
      dc      = 16'($urandom);
      dc[2:0] = 3'(modes[$urandom_range(0, 8)]);
      row     = $urandom_range(0, 200);
      run_line(dc, row, 1'b1, PER);
    end

    // Reset during FILL.
    run_line(16'h0003, 30, 1'b1, 20);
    check("vram_rd mid fill", {31'd0, vram_rd}, 32'd1);
    #2;
    clrn = 1'b0;
    #1;
    check("mid reset busy", {31'd0, busy}, 32'd0);
    check("mid reset vram_rd", {31'd0, vram_rd}, 32'd0);
    check("mid reset pix_data", {17'd0, pix_data}, 32'd0);
    check("mid reset overrun", {31'd0, overrun}, 32'd0);
    prev_known = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    run_line(16'h0004, 77, 1'b0, PER);
    run_line(16'h0003, 90, 1'b1, PER);
    run_line(16'h0000, 0, 1'b1, PER);

    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
